// File: rtl/bp_update_queue.sv
// Branch-predictor update queue.
// Collects resolved-branch updates from NUM_WR resolution lanes, compacts the valid lanes of
// each cycle in ascending lane order, and drains them one per cycle into the predictor's
// single write port. Occupancy is tracked by a registered count; pointers only address storage.

`ifndef BRANCH_HISTORY_REG_SZ
`define BRANCH_HISTORY_REG_SZ 16
`endif

module bp_update_queue #(
    parameter int unsigned NUM_WR      = 2,
    parameter int unsigned QUEUE_DEPTH = 8,
    parameter int unsigned BHR_DEPTH   = `BRANCH_HISTORY_REG_SZ,
    parameter int unsigned ADDR        = 32
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [NUM_WR-1:0]                   in_valid,
    input  logic [NUM_WR-1:0]                   in_taken,
    input  logic [NUM_WR*ADDR-1:0]              in_pc,
    input  logic [NUM_WR*ADDR-1:0]              in_target,
    input  logic [NUM_WR*BHR_DEPTH-1:0]         in_bhr,
    output logic                                in_ready,
    output logic                                wr_en,
    output logic                                wr_taken,
    output logic [ADDR-1:0]                     wr_target,
    output logic [ADDR-1:0]                     wr_pc,
    output logic [BHR_DEPTH-1:0]                wr_bhr,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]    count,
    output logic                                overflow_err
);

    localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);
    localparam int unsigned CntW = $clog2(QUEUE_DEPTH + 1);

    // Payload storage; deliberately not reset.
    logic                 taken_mem  [QUEUE_DEPTH];
    logic [ADDR-1:0]      pc_mem     [QUEUE_DEPTH];
    logic [ADDR-1:0]      target_mem [QUEUE_DEPTH];
    logic [BHR_DEPTH-1:0] bhr_mem    [QUEUE_DEPTH];

    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;
    logic            ovf_q, ovf_d;

    logic [CntW:0]     free_slots;
    logic              deq;
    logic [CntW-1:0]   enq_cnt;
    logic [PtrW-1:0]   enq_off;
    logic [NUM_WR-1:0] lane_we;
    logic [PtrW-1:0]   lane_slot [NUM_WR];

    // Admission: only the registered count decides; a same-cycle dequeue is not credited.
    always_comb begin
        free_slots = (CntW+1)'(QUEUE_DEPTH) - {1'b0, count_q};
        in_ready   = free_slots >= (CntW+1)'(NUM_WR);
    end

    // Compact valid lanes onto consecutive slots starting at tail, lane 0 first.
    always_comb begin
        enq_off = '0;
        enq_cnt = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            lane_we[i]   = in_ready & in_valid[i];
            lane_slot[i] = tail_q + enq_off;
            if (lane_we[i]) begin
                enq_off = enq_off + PtrW'(1);
                enq_cnt = enq_cnt + CntW'(1);
            end
        end
    end

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        deq     = (count_q != '0);
        head_d  = head_q + PtrW'(deq);
        tail_d  = tail_q + enq_off;
        count_d = count_q + enq_cnt - CntW'(deq);
        ovf_d   = ovf_q | ((|in_valid) & ~in_ready);
    end

    // Control state, cleared asynchronously; in-flight entries are simply forgotten.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Payload write; compacted slots of one cycle never collide.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_WR; i++) begin
            if (lane_we[i]) begin
                taken_mem[lane_slot[i]]  <= in_taken[i];
                pc_mem[lane_slot[i]]     <= in_pc[i*ADDR +: ADDR];
                target_mem[lane_slot[i]] <= in_target[i*ADDR +: ADDR];
                bhr_mem[lane_slot[i]]    <= in_bhr[i*BHR_DEPTH +: BHR_DEPTH];
            end
        end
    end

    // Head entry drives the predictor write port; zeros when the queue is empty.
    always_comb begin
        wr_en     = deq;
        wr_taken  = 1'b0;
        wr_pc     = '0;
        wr_target = '0;
        wr_bhr    = '0;
        if (deq) begin
            wr_taken  = taken_mem[head_q];
            wr_pc     = pc_mem[head_q];
            wr_target = target_mem[head_q];
            wr_bhr    = bhr_mem[head_q];
        end
    end

    assign count        = count_q;
    assign overflow_err = ovf_q;

endmodule
